// File: rtl/temp_sensor_reader_pkg.sv
// Shared types and constants for the temperature front-end.
// FSM state encoding, default thresholds and the hysteresis rule.
package temp_sensor_reader_pkg;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_LATCH = 3'd4
  } state_e;

  localparam logic [7:0] T28_DEFAULT = 8'd28;
  localparam logic [7:0] T30_DEFAULT = 8'd30;

  // Set at/above thr, clear once s+hyst drops below thr,
  // hold in between. 9-bit sum so large codes cannot wrap.
  function automatic logic hyst_flag(
    input logic [7:0] s,
    input logic [7:0] thr,
    input logic [7:0] hyst,
    input logic       cur
  );
    logic [8:0] sum;
    sum = {1'b0, s} + {1'b0, hyst};
    if (s >= thr)
      return 1'b1;
    else if (sum < {1'b0, thr})
      return 1'b0;
    else
      return cur;
  endfunction

endpackage

// File: rtl/temp_sensor_reader_sync_2ff.sv
// 1-bit two-flop synchronizer, async active-low reset to 0.
// Ports: clk, reset_n, d_i (async in), q_o (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/temp_sensor_reader.sv
// Serial ADC reader: periodic 8-bit conversions, sample output
// and hysteresis flags Temp_28/Temp_30 for the control FSM.
module temp_sensor_reader
  import temp_sensor_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter logic [7:0]  T28_CODE   = T28_DEFAULT,
  parameter logic [7:0]  T30_CODE   = T30_DEFAULT,
  parameter logic [7:0]  HYST       = 8'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adc_sdata,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] temp,
  output logic       temp_valid,
  output logic       Temp_28,
  output logic       Temp_30
);

  localparam int unsigned PH_MAX =
    (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int unsigned PH_W = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] GAP_LAST =
    PH_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0] DIV_LAST =
    PH_W'(CLK_DIV - 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      temp_q, temp_d;
  logic            valid_q, valid_d;
  logic            t28_q, t28_d;
  logic            t30_q, t30_d;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            sdata_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (adc_sdata),
    .q_o     (sdata_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    t28_d   = t28_q;
    t30_d   = t30_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          bit_d   = 3'd7;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          // Sample late in the high phase so the synchronizer
          // has caught up with the bit driven before the edge.
          shift_d = {shift_q[6:0], sdata_s};
          cnt_d   = '0;
          if (bit_q == 3'd0) begin
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        temp_d  = shift_q;
        valid_d = 1'b1;
        t28_d   = hyst_flag(shift_q, T28_CODE, HYST, t28_q);
        t30_d   = hyst_flag(shift_q, T30_CODE, HYST, t30_q);
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
    // ADC pins are registered copies of the next state.
    cs_n_d = (state_d == S_WAIT) || (state_d == S_LATCH);
    sclk_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      t28_q   <= 1'b0;
      t30_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      t28_q   <= t28_d;
      t30_q   <= t30_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign temp       = temp_q;
  assign temp_valid = valid_q;
  assign Temp_28    = t28_q;
  assign Temp_30    = t30_q;

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Front-end for the infant-asphyxia prevention unit. Periodically reads an 8-bit temperature sample from a serial (SPI-style, read-only) ADC, publishes the sample, and produces the hysteresis-filtered threshold flags `Temp_28` and `Temp_30`. The FSM controlling `Ventilador` and `Alarma` consumes these flags. This block is the producing end of that temperature-flag interface.

## Interface
Parameters:
- `CLK_DIV`, default 25: `clk` cycles per SCLK half-period. Must be at least 3.
- `GAP_CYCLES`, default 1000: idle `clk` cycles between conversions (CS_n high). Must be at least 1.
- `T28_CODE`, default 8'd28: ADC code for 28 °C (1 LSB = 1 °C).
- `T30_CODE`, default 8'd30: ADC code for 30 °C. Must be greater than `T28_CODE`.
- `HYST`, default 8'd1: hysteresis width in codes. Must be less than `T28_CODE`.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `adc_sdata` in 1: serial data from the ADC, asynchronous to `clk`.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_sclk` out 1: ADC serial clock.
- `temp` out 8: last completed sample.
- `temp_valid` out 1: one-cycle pulse when `temp` updates.
- `Temp_28` out 1: temperature at or above 28 °C, with hysteresis.
- `Temp_30` out 1: temperature at or above 30 °C, with hysteresis.

## Operation
- Reset values (asynchronous): `adc_cs_n`=1, `adc_sclk`=0, `temp`=0, `temp_valid`=0, `Temp_28`=0, `Temp_30`=0. State is WAIT with the counter at 0.
- `adc_sdata` passes through a two-flop synchronizer before any use.
- WAIT:
  - `adc_cs_n`=1, `adc_sclk`=0.
  - Stays for `GAP_CYCLES` cycles, then goes to SETUP.
- SETUP:
  - `adc_cs_n`=0, `adc_sclk`=0.
  - Stays for `CLK_DIV` cycles, then goes to LOW with bit counter = 7.
- LOW: `adc_sclk`=0 for `CLK_DIV` cycles, then goes to HIGH.
- HIGH:
  - `adc_sclk`=1 for `CLK_DIV` cycles.
  - On the last cycle, shift the synchronized `adc_sdata` into the shift register. Bits arrive MSB first.
  - If bit counter = 0, go to LATCH. Otherwise decrement the counter and go to LOW.
- LATCH (1 cycle):
  - `adc_cs_n`=1.
  - `temp` <= shift register; `temp_valid`=1 on the following cycle only.
  - Flags update from the new sample, then go to WAIT.
- Each CS_n-low window contains exactly 8 SCLK rising edges. `adc_sclk` is registered and glitch-free.
- Hysteresis uses 9-bit comparisons so no underflow occurs:
  - `Temp_28` sets when `temp` >= `T28_CODE`.
  - `Temp_28` clears when `temp` + `HYST` < `T28_CODE`.
  - Otherwise `Temp_28` holds its value.
  - `Temp_30` follows the same rules with `T30_CODE`.
- Flags change only in LATCH. They are constant between `temp_valid` pulses.
- Saturated samples: 8'hFF sets both flags; 8'h00 clears both.
- Reset mid-conversion: all outputs return to reset values immediately and the partial sample is discarded. After release, the first conversion begins after a full WAIT.

## Timing
- Conversion period: `GAP_CYCLES` + 17·`CLK_DIV` + 1 cycles, measured from one `temp_valid` pulse to the next.
- The first `temp_valid` occurs `GAP_CYCLES` + 17·`CLK_DIV` + 2 cycles after `reset_n` deasserts.
- The sample point is `CLK_DIV`−1 cycles after the SCLK rising edge. With `CLK_DIV` ≥ 3, this covers the 2-cycle synchronizer latency.
- SCLK frequency is f_clk / (2·`CLK_DIV`): 1 MHz at 50 MHz with the defaults.
- The ADC must drive a bit at or before the SCLK rising edge and hold it until the next falling edge.
- `temp`, `Temp_28`, and `Temp_30` change in the same cycle that `temp_valid` is high.

## Structure
- Shared package holds:
  - state encoding localparams (WAIT, SETUP, LOW, HIGH, LATCH; 3 bits);
  - default threshold constants 28 and 30, shared with the control FSM.
- Sub-module `sync_2ff`: a 1-bit, two-flop synchronizer with asynchronous active-low reset clearing to 0. Also reusable for the `Presencia` and `Ignicion` inputs.
- Counters:
  - one phase counter sized for max(`GAP_CYCLES`, `CLK_DIV`);
  - one 3-bit bit counter;
  - one 8-bit shift register.

## Test plan
- **Reset:** hold `reset_n`=0 → `adc_cs_n`=1, `adc_sclk`=0, `temp`=0, flags 0. Release → no SCLK activity for `GAP_CYCLES` cycles.
- **Bit order and edge count:** ADC model serves 8'hA5 → `temp`=8'hA5; exactly 8 rising edges while CS_n is low; `temp_valid` high for exactly 1 cycle.
- **Hysteresis:** sample sequence 29, 30, 29, 28, 27, 26 with `HYST`=1:
  - `Temp_28`: 1, 1, 1, 1, 1, 0.
  - `Temp_30`: 0, 1, 1, 0, 0, 0.
- **Period:** with `CLK_DIV`=3 and `GAP_CYCLES`=4, `temp_valid` pulses every 56 cycles. The first pulse occurs 57 cycles after reset release.
- **Reset mid-conversion:** assert `reset_n`=0 during bit 4 → `adc_cs_n`=1 and `adc_sclk`=0 immediately; no `temp_valid`; `temp` stays 0. The next sample after release is correct.
- **Extremes:** 8'hFF → both flags 1; then 8'h00 → both flags 0.
